// File: rtl/alu_stage.sv
// Single-stage ALU with a valid/ready handshake on both sides.
// Results pass through a two-entry skid buffer: main register drives the outputs, skid absorbs one stall.
module alu_stage #(
    parameter int unsigned D_W = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           vld_s,
    output logic           rdy_s,
    input  logic [D_W-1:0] x_s,
    input  logic [D_W-1:0] y_s,
    input  logic           zx_s,
    input  logic           nx_s,
    input  logic           zy_s,
    input  logic           ny_s,
    input  logic           f_s,
    input  logic           no_s,
    input  logic [2:0]     j_s,
    input  logic [2:0]     d_s,
    output logic           vld_m,
    input  logic           rdy_m,
    output logic [D_W-1:0] out_m,
    output logic           zr_m,
    output logic           ng_m,
    output logic           jmp_m,
    output logic [2:0]     dst_m
);

    localparam int unsigned E_W = D_W + 6;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         state, state_nxt;
    logic           rdy_q, vld_q;
    logic [D_W-1:0] x1, x2, y1, y2, o, res;
    logic           res_zr, res_ng, res_jmp;
    logic [E_W-1:0] new_e, main_q, skid_q;
    logic           up, dn;
    logic           load_main_new, load_main_skid, load_skid;

    always_comb begin
        x1      = zx_s ? '0 : x_s;
        x2      = nx_s ? ~x1 : x1;
        y1      = zy_s ? '0 : y_s;
        y2      = ny_s ? ~y1 : y1;
        o       = f_s ? (x2 + y2) : (x2 & y2);
        res     = no_s ? ~o : o;
        res_zr  = (res == '0);
        res_ng  = res[D_W-1];
        // j_s = {lt, eq, gt}
        res_jmp = (j_s[2] & res_ng) | (j_s[1] & res_zr) | (j_s[0] & ~res_ng & ~res_zr);
        new_e   = {res, res_zr, res_ng, res_jmp, d_s};
    end

    assign up = vld_s & rdy_q;
    assign dn = vld_q & rdy_m;

    always_comb begin
        state_nxt      = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (up) begin
                    load_main_new = 1'b1;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                if (up && dn) begin
                    load_main_new = 1'b1;
                end else if (up) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (dn) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (dn) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so they never depend combinationally on rdy_m.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != FULL);
            vld_q <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new) begin
                main_q <= new_e;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_e;
            end
        end
    end

    assign {out_m, zr_m, ng_m, jmp_m, dst_m} = main_q;
    assign vld_m = vld_q;
    assign rdy_s = rdy_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: queue-based reference model checked every cycle,
// plus directed literal cases, backpressure ordering, pass-through and asynchronous reset.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        vld_s = 1'b0;
    logic        rdy_s;
    logic [15:0] x_s = '0;
    logic [15:0] y_s = '0;
    logic        zx_s, nx_s, zy_s, ny_s, f_s, no_s;
    logic [5:0]  ctrl = '0;
    logic [2:0]  j_s = '0;
    logic [2:0]  d_s = '0;
    logic        vld_m;
    logic        rdy_m = 1'b0;
    logic [15:0] out_m;
    logic        zr_m, ng_m, jmp_m;
    logic [2:0]  dst_m;

    assign {zx_s, nx_s, zy_s, ny_s, f_s, no_s} = ctrl;

    alu_stage #(.D_W(16)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .vld_s (vld_s),
        .rdy_s (rdy_s),
        .x_s   (x_s),
        .y_s   (y_s),
        .zx_s  (zx_s),
        .nx_s  (nx_s),
        .zy_s  (zy_s),
        .ny_s  (ny_s),
        .f_s   (f_s),
        .no_s  (no_s),
        .j_s   (j_s),
        .d_s   (d_s),
        .vld_m (vld_m),
        .rdy_m (rdy_m),
        .out_m (out_m),
        .zr_m  (zr_m),
        .ng_m  (ng_m),
        .jmp_m (jmp_m),
        .dst_m (dst_m)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        jmp;
        logic [2:0]  dst;
    } exp_t;

    exp_t        q[$];
    logic [15:0] got[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          cmp_up, cmp_dn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, bitwise complement expressed as 0xFFFF - v.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic [5:0] c, input logic [2:0] j, input logic [2:0] d);
        int unsigned xv, yv, ov;
        exp_t e;
        xv = c[5] ? 0 : int'(x);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : int'(y);
        if (c[2]) yv = 65535 - yv;
        ov = c[1] ? (xv + yv) % 65536 : (xv & yv);
        if (c[0]) ov = 65535 - ov;
        e.out = ov[15:0];
        e.zr  = (ov == 0);
        e.ng  = (ov >= 32768);
        e.jmp = (j[2] && e.ng) || (j[1] && e.zr) || (j[0] && !e.ng && !e.zr);
        e.dst = d;
        return e;
    endfunction

    // Outputs are checked on the falling edge; the transfer about to happen on the next rising edge
    // is decided from the model occupancy and the inputs, which are stable by then.
    always @(negedge clk) begin
        if (rstn) begin
            chk("vld_m", {31'b0, vld_m}, {31'b0, (q.size() > 0)});
            chk("rdy_s", {31'b0, rdy_s}, {31'b0, (q.size() < 2)});
            if (q.size() > 0) begin
                chk("out_m", {16'b0, out_m}, {16'b0, q[0].out});
                chk("zr_m",  {31'b0, zr_m},  {31'b0, q[0].zr});
                chk("ng_m",  {31'b0, ng_m},  {31'b0, q[0].ng});
                chk("jmp_m", {31'b0, jmp_m}, {31'b0, q[0].jmp});
                chk("dst_m", {29'b0, dst_m}, {29'b0, q[0].dst});
            end
            cmp_dn = (q.size() > 0) && rdy_m;
            cmp_up = vld_s && (q.size() < 2);
            if (cmp_dn) begin
                got.push_back(out_m);
                void'(q.pop_front());
            end
            if (cmp_up) q.push_back(model(x_s, y_s, ctrl, j_s, d_s));
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                        input logic [2:0] j, input logic [2:0] d);
        bit acc = 1'b0;
        x_s = x; y_s = y; ctrl = c; j_s = j; d_s = d; vld_s = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = rdy_s;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        vld_s = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c, input logic [2:0] j, input logic [2:0] d,
                         input logic [15:0] e_out, input logic e_zr, input logic e_ng, input logic e_jmp);
        x_s = x; y_s = y; ctrl = c; j_s = j; d_s = d; vld_s = 1'b1; rdy_m = 1'b1;
        @(posedge clk);
        #1;
        vld_s = 1'b0;
        chk({nm, "_vld"}, {31'b0, vld_m}, 32'd1);
        chk({nm, "_out"}, {16'b0, out_m}, {16'b0, e_out});
        chk({nm, "_zr"},  {31'b0, zr_m},  {31'b0, e_zr});
        chk({nm, "_ng"},  {31'b0, ng_m},  {31'b0, e_ng});
        chk({nm, "_jmp"}, {31'b0, jmp_m}, {31'b0, e_jmp});
        chk({nm, "_dst"}, {29'b0, dst_m}, {29'b0, d});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_vld_m", {31'b0, vld_m}, 32'd0);
        chk("rst_rdy_s", {31'b0, rdy_s}, 32'd1);
        chk("rst_out_m", {16'b0, out_m}, 32'd0);
        chk("rst_flags", {29'b0, zr_m, ng_m, jmp_m}, 32'd0);
        chk("rst_dst_m", {29'b0, dst_m}, 32'd0);
        q.delete();
        got.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rstn = 1'b0;
        #1;
        chk("init_vld_m", {31'b0, vld_m}, 32'd0);
        chk("init_rdy_s", {31'b0, rdy_s}, 32'd1);
        chk("init_out_m", {16'b0, out_m}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Directed literal cases
        do_op("add53",   16'h0005, 16'h0003, 6'b000010, 3'b000, 3'b101, 16'h0008, 1'b0, 1'b0, 1'b0);
        do_op("one",     16'h1234, 16'hABCD, 6'b111111, 3'b000, 3'b010, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op("minus1",  16'h1234, 16'hABCD, 6'b111010, 3'b100, 3'b001, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        do_op("ovf",     16'h7FFF, 16'h0001, 6'b000010, 3'b011, 3'b111, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op("and0",    16'h0000, 16'h0000, 6'b000000, 3'b010, 3'b100, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: four entries with downstream stalled for three cycles
        got.delete();
        rdy_m = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(16'(i), 16'h0000, 6'b000010, 3'b000, 3'b000);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("full_rdy_s", {31'b0, rdy_s}, 32'd0);
                chk("full_vld_m", {31'b0, vld_m}, 32'd1);
                rdy_m = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_count", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_order", {16'b0, got[i]}, 32'(i + 1));

        // Streaming: simultaneous transfer on both sides every cycle
        rdy_m = 1'b1;
        vld_s = 1'b1;
        ctrl  = 6'b000010;
        y_s   = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            x_s = 16'(i + 16);
            @(posedge clk);
            #1;
            chk("stream_rdy_s", {31'b0, rdy_s}, 32'd1);
            chk("stream_vld_m", {31'b0, vld_m}, 32'd1);
        end
        vld_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while FULL, then immediate acceptance
        rdy_m = 1'b0;
        send(16'h0011, 16'h0022, 6'b000010, 3'b000, 3'b000);
        send(16'h0033, 16'h0044, 6'b000010, 3'b000, 3'b000);
        chk("pre_rst_rdy_s", {31'b0, rdy_s}, 32'd0);
        rst_pulse();
        x_s = 16'h0005; y_s = 16'h0003; ctrl = 6'b000010; j_s = 3'b000; d_s = 3'b011;
        vld_s = 1'b1;
        rdy_m = 1'b1;
        @(posedge clk);
        #1;
        vld_s = 1'b0;
        chk("post_rst_vld_m", {31'b0, vld_m}, 32'd1);
        chk("post_rst_out_m", {16'b0, out_m}, 32'h0008);
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            vld_s = ($urandom_range(0, 3) != 0);
            rdy_m = ($urandom_range(0, 3) != 0);
            x_s   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            y_s   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            ctrl  = 6'($urandom);
            j_s   = 3'($urandom);
            d_s   = 3'($urandom);
            @(posedge clk);
            #1;
        end
        vld_s = 1'b0;
        rdy_m = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_vld_m", {31'b0, vld_m}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter: D_W, 16, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: vld_s  input  1  upstream (source select) operand valid.
REQ-005 SHALL have port: rdy_s  output  1  ready to accept upstream operand.
REQ-006 SHALL have port: x_s, y_s  input  D_W each  ALU operands.
REQ-007 SHALL have port: zx_s, nx_s, zy_s, ny_s, f_s, no_s  input  1 each  ALU control bits (zero-ize x, negate x, zero-ize y, negate y, 1 = add / 0 = and, negate output).
REQ-008 SHALL have port: j_s  input  3  jump bits {j1 = lt, j2 = eq, j3 = gt}.
REQ-009 SHALL have port: d_s  input  3  destination bits {A, D, M}; carried through unmodified.
REQ-010 SHALL have port: vld_m  output  1  result valid to downstream.
REQ-011 SHALL have port: rdy_m  input  1  downstream ready.
REQ-012 SHALL have port: out_m  output  D_W  ALU result.
REQ-013 SHALL have port: zr_m, ng_m  output  1 each  result == 0; result MSB.
REQ-014 SHALL have port: jmp_m  output  1  jump-taken flag.
REQ-015 SHALL have port: dst_m  output  3  registered copy of d_s.

Function
REQ-016 SHALL, on acceptance, compute: x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1; y1/y2 likewise with zy/ny; o = f ? (x2 + y2) mod 2^D_W : x2 & y2; out = no ? ~o : o. Carry-out is discarded.
REQ-017 SHALL derive zr = (out == 0), ng = out[D_W-1], jmp = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr).
REQ-018 SHALL transfer on upstream when vld_s & rdy_s at a clock edge, and on downstream when vld_m & rdy_m at a clock edge.
REQ-019 SHALL register the computed {out, zr, ng, jmp, dst}: latency of exactly one cycle from upstream transfer to vld_m in the EMPTY state.
REQ-020 SHALL hold two entries: a main (output) register and a skid register; outputs are driven only from the main register.
REQ-021 SHALL implement the state machine EMPTY / ONE / FULL; vld_m = (state != EMPTY); rdy_s = (state != FULL), driven from a register.
REQ-022 EMPTY: upstream transfer -> main loads, go to ONE.
REQ-023 ONE: upstream transfer only -> skid loads, go to FULL; downstream transfer only -> EMPTY; both in the same cycle -> main loads the new entry, stay ONE.
REQ-024 FULL: no upstream transfer is possible; downstream transfer -> main <= skid, go to ONE.
REQ-025 SHALL keep out_m, zr_m, ng_m, jmp_m and dst_m stable while vld_m = 1 and rdy_m = 0.
REQ-026 SHALL preserve order, and SHALL neither drop nor duplicate any entry under any vld_s/rdy_m pattern.
REQ-027 SHALL ignore operand and control inputs when vld_s = 0, and SHALL ignore rdy_m when vld_m = 0.

Reset
REQ-028 SHALL, on rstn = 0, immediately (asynchronously) force state = EMPTY, vld_m = 0, rdy_s = 1, and out_m, zr_m, ng_m, jmp_m, dst_m = 0.
REQ-029 SHALL discard all in-flight entries if reset asserts mid-operation; the first upstream transfer after rstn rises SHALL be accepted on the first clock edge.

Verification
REQ-030 SHALL cover: x = 0x0005, y = 0x0003, controls 000010, rdy_m = 1 -> one cycle later out_m = 0x0008, zr = 0, ng = 0.
REQ-031 SHALL cover: controls 111111 with any x, y -> out_m = 0x0001; controls 111010 -> out_m = 0xFFFF, ng = 1, and j_s = 100 gives jmp_m = 1.
REQ-032 SHALL cover: x = 0x7FFF, y = 0x0001, add, j_s = 011 -> out_m = 0x8000, ng = 1, jmp_m = 0; x = y = 0x0000, and (f = 0), j_s = 010 -> zr = 1, jmp_m = 1.
REQ-033 SHALL cover: vld_s held high with sequence 1, 2, 3, 4 while rdy_m = 0 for 3 cycles -> two entries accepted, rdy_s = 0 in FULL, then out_m delivers 1, 2, 3, 4 in order after rdy_m = 1, with no loss.
REQ-034 SHALL cover: state ONE with simultaneous upstream and downstream transfer each cycle -> one result per cycle, state stays ONE, rdy_s stays 1.
REQ-035 SHALL cover: rstn pulsed low while FULL -> vld_m = 0 and rdy_s = 1 without waiting for a clock edge; the next operand appears on out_m one cycle after acceptance.
